// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer: one full-adder cell processes one bit pair per clock,
// LSB first, with the carry kept in a flip-flop and a start/done handshake.

module FullAdder_1bit (
    input  logic in0,
    input  logic in1,
    input  logic carry_in,
    output logic sum_out,
    output logic carry_out
);
    assign sum_out   = in0 ^ in1 ^ carry_in;
    assign carry_out = (in0 & in1) | (carry_in & (in0 ^ in1));
endmodule

module serial_addsub_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             overflow_reg;
    logic             zero_reg;

    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic [WIDTH-1:0] acc_next;

    FullAdder_1bit u_fa (
        .in0       (sa_reg[0]),
        .in1       (sb_reg[0]),
        .carry_in  (carry_reg),
        .sum_out   (fa_sum),
        .carry_out (fa_cout)
    );

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));
    assign acc_next = {fa_sum, acc_reg[WIDTH-1:1]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Subtraction is a + ~b + 1: the +1 enters through the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_reg        <= '0;
            sb_reg        <= '0;
            acc_reg       <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sa_reg    <= a;
                        sb_reg    <= op_sub ? ~b : b;
                        carry_reg <= op_sub;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    sa_reg    <= sa_reg >> 1;
                    sb_reg    <= sb_reg >> 1;
                    acc_reg   <= acc_next;
                    carry_reg <= fa_cout;
                    cnt_reg   <= cnt_reg + CW'(1);
                    // On the MSB the adder's carry_in is the carry into the sign bit,
                    // so signed overflow is that XOR the final carry.
                    if (last_bit) begin
                        result_reg    <= acc_next;
                        carry_out_reg <= fa_cout;
                        overflow_reg  <= carry_reg ^ fa_cout;
                        zero_reg      <= (acc_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed bench for serial_addsub_seq: vector table of single operations plus
// start-while-busy and reset-mid-operation sequences.

module tb_serial_addsub_seq;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    int checks   = 0;
    int failures = 0;

    serial_addsub_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Run one operation from IDLE; checks handshake, latency, output hold and results.
    task automatic do_op(input vec_t v);
        int cycles;
        logic [7:0] prev_res;
        @(negedge clk);
        prev_res = result;
        a = v.a; b = v.b; op_sub = v.sub; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 8'h00; b = 8'h00; op_sub = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("result_held_in_run", {24'd0, result}, {24'd0, prev_res});
        cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("done_latency", cycles, 32'd8);
        check("result", {24'd0, result}, {24'd0, v.res});
        check("carry_out", {31'd0, carry_out}, {31'd0, v.c});
        check("overflow", {31'd0, overflow}, {31'd0, v.v});
        check("zero", {31'd0, zero}, {31'd0, v.z});
        check("busy_in_done", {31'd0, busy}, 32'd1);
        $display("op a=0x%02h b=0x%02h sub=%0d -> result=0x%02h c=%0d v=%0d z=%0d (%0d cycles)",
                 v.a, v.b, v.sub, result, carry_out, overflow, zero, cycles);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("result_hold_idle", {24'd0, result}, {24'd0, v.res});
    endtask

    initial begin
        int done_cnt;
        int done_cyc;
        int cycles;
        logic [7:0] got;
        vec_t v;

        vecs[0] = '{8'h25, 8'h3A, 1'b0, 8'h5F, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'hC3, 8'hA5, 1'b0, 8'h68, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{8'h55, 8'hAA, 1'b1, 8'hAB, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) do_op(vecs[i]);

        // Start while busy: 0x01+0x01, with ignored start pulses in cycle 3 and the DONE cycle.
        @(negedge clk);
        a = 8'h01; b = 8'h01; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        done_cnt = 0; done_cyc = 0; got = 8'h00;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                got = result;
            end
            start = (cyc == 3 || cyc == 9);
            a = start ? 8'hAA : 8'h00;
            b = start ? 8'h11 : 8'h00;
        end
        check("busy_start_done_count", done_cnt, 32'd1);
        check("busy_start_done_cycle", done_cyc, 32'd9);
        check("busy_start_result", {24'd0, got}, 32'h02);
        $display("op a=0x01 b=0x01 sub=0 with start pulses while busy -> result=0x%02h dones=%0d",
                 got, done_cnt);
        @(negedge clk);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0; a = 8'h00; b = 8'h00;
        check("held_start_accepted", {31'd0, busy}, 32'd1);
        cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("held_start_latency", cycles, 32'd8);
        check("held_start_result", {24'd0, result}, 32'hBB);
        $display("op a=0xAA b=0x11 sub=0 (held start) -> result=0x%02h", result);

        // Reset at cycle 4 of RUN clears outputs without waiting for an edge.
        @(negedge clk);
        a = 8'h55; b = 8'h11; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_result", {24'd0, result}, 32'd0);
        $display("reset asserted mid-run -> busy=%0d done=%0d result=0x%02h", busy, done, result);
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no_done_after_abort", done_cnt, 32'd0);
        rst_n = 1'b1;
        v = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0};
        do_op(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
